fcl_weight_store: RTL
=====================

Name: fcl_weight_store

Overview:
- Parametrised weight store and initialiser for a fully connected layer.
- Holds the (IN_DIM+1) x OUT_DIM signed weight/bias array. Row IN_DIM is the bias row.
- After reset, fills the array one row per cycle from per-lane LFSRs in a selectable mode, then serves weights to the layer.
- Accepts whole-array updates from the layer's backprop path through a valid/ready handshake; supports re-initialisation on request.

Parameters:
- WIDTH, 16, weight word width in bits; legal range 2..16.
- IN_DIM, 4, layer input count; the array has IN_DIM+1 rows.
- OUT_DIM, 10, layer output count = columns = LFSR lanes.
- SEED, 16'hACE1, base LFSR seed.
- INIT_SHIFT, 0, arithmetic right shift applied to random init values (0..WIDTH-1).
- CLAMP_LIMIT, 8192, magnitude limit used only when WSTORE_CLAMP_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  init mode: 00 zero, 01 random, 10 random shifted by INIT_SHIFT, 11 reserved (treated as zero).
- init_req  in  1  request re-initialisation; honoured in RUN only.
- update_valid  in  1  update_weights holds a new array.
- update_weights  in  [IN_DIM+1][OUT_DIM] x WIDTH signed  new array from the layer.
- update_ready  out  1  store will accept an update this cycle.
- weights  out  [IN_DIM+1][OUT_DIM] x WIDTH signed  registered weight array.
- weights_valid  out  1  weights are complete and usable.
- init_busy  out  1  high while in INIT.
- update_count  out  16  accepted updates since the last init; saturates at 16'hFFFF.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: all weights 0, weights_valid 0, init_busy 0, update_count 0, state IDLE, row counter 0, latched mode 00, LFSR lanes reseeded.
- LFSR lanes:
  - Lane j is 16 bits, Fibonacci, shift-left. Feedback bit = b15^b13^b12^b10 (x^16+x^14+x^13+x^11+1).
  - Seed of lane j = SEED ^ (j*16'h9E37), truncated to 16 bits; a zero result is replaced by 16'h0001.
  - Lanes step once per INIT cycle only; they hold in IDLE and RUN.
  - Lanes are not reseeded on re-init, so each init produces a fresh sequence.
- Random value for lane j = the current lane state before the step, low WIDTH bits taken as signed.
  - Mode 10 additionally applies >>> INIT_SHIFT (arithmetic, sign-preserving).
  - Mode 00 and mode 11 write 0.
- State machine:
  - IDLE: lasts one cycle, then goes to INIT. Latches mode and clears the row counter.
  - INIT: writes row r (all OUT_DIM columns) each cycle, r = 0..IN_DIM. After writing row IN_DIM, goes to RUN. Total IN_DIM+1 cycles. init_busy=1, weights_valid=0, update_ready=0.
  - RUN: weights_valid=1 from the first RUN cycle. update_ready = !init_req (combinational).
- In RUN with init_req=1:
  - Next state is INIT; mode is latched that cycle and update_count is cleared.
  - weights_valid is 0 from the next cycle.
  - Weights keep their old values until each row is overwritten.
- Update handshake:
  - Transfer occurs when update_valid && update_ready.
  - weights <= update_weights on the next edge; update_count increments (saturating).
  - Update is all-or-nothing, with no partial-row writes.
- Simultaneous init_req and update_valid in RUN: init wins. The update is not accepted (ready is low).
- update_valid outside RUN is ignored and has no effect.
- init_req outside RUN is ignored; requests are not queued.
- Reset asserted mid-INIT or mid-update: state returns to IDLE and all reset values apply on the next edge.
- Mode changes during INIT have no effect until the next init.

Optional Feature:
- Macro: WSTORE_CLAMP_EN.
- When defined: each accepted update element is saturated to [-CLAMP_LIMIT, +CLAMP_LIMIT] before storing. Init values are unaffected.
- When undefined: update elements are stored verbatim, and CLAMP_LIMIT is unused.

Test Plan:
- Reset, mode=01, defaults -> one IDLE cycle, INIT for 5 cycles, weights[0][0]=16'hACE1, weights[1][0]=16'h59C3, weights_valid rises 6 cycles after reset release.
- Reset, mode=10, INIT_SHIFT=2 -> weights[0][0]=16'hEB38, all other elements = arithmetic shift of their lane values.
- Mode=00 -> all 50 weights 0 after init; mode=11 gives the same result.
- In RUN, update_valid=1 with all elements 16'h0123 for 3 cycles -> weights=16'h0123 throughout, update_count=3; with update_valid held, update_count stops at 16'hFFFF.
- RUN, init_req and update_valid high in the same cycle -> update_ready=0, update not applied, INIT entered, update_count=0, new row 0 differs from the first init.
- WSTORE_CLAMP_EN defined, update element 16'sd20000 / -16'sd20000 -> stored as 8192 / -8192; undefined -> stored as 20000 / -20000.

Source files
------------

// File: rtl/fcl_weight_store_if.sv
// Bus between a fully connected layer and its weight store: init control,
// whole-array update handshake and the served weight array.
interface fcl_weight_store_if #(
  parameter int WIDTH   = 16,
  parameter int IN_DIM  = 4,
  parameter int OUT_DIM = 10
);
  logic [1:0]                                mode;
  logic                                      init_req;
  // Handshake: a whole array transfers on a cycle where update_valid && update_ready;
  // update_ready may depend combinationally on init_req, never on update_valid.
  logic                                      update_valid;
  logic [IN_DIM:0][OUT_DIM-1:0][WIDTH-1:0]   update_weights;
  logic                                      update_ready;
  logic [IN_DIM:0][OUT_DIM-1:0][WIDTH-1:0]   weights;
  logic                                      weights_valid;
  logic                                      init_busy;
  logic [15:0]                               update_count;

  modport master (
    output mode, init_req, update_valid, update_weights,
    input  update_ready, weights, weights_valid, init_busy, update_count
  );

  modport slave (
    input  mode, init_req, update_valid, update_weights,
    output update_ready, weights, weights_valid, init_busy, update_count
  );
endinterface

// File: rtl/fcl_weight_store.sv
// Weight/bias store for a fully connected layer: LFSR row-per-cycle init, then
// serves weights and takes whole-array updates. Optional macro: WSTORE_CLAMP_EN.
module fcl_weight_store #(
  parameter int          WIDTH       = 16,
  parameter int          IN_DIM      = 4,
  parameter int          OUT_DIM     = 10,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          INIT_SHIFT  = 0,
  parameter int          CLAMP_LIMIT = 8192
) (
  input  logic                 clk,
  input  logic                 reset,
  fcl_weight_store_if.slave    bus,
  output logic [1:0]           dbg_state
);
  localparam int ROWS = IN_DIM + 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

`ifdef WSTORE_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_INIT = 2'd1, S_RUN = 2'd2} state_t;
  typedef logic [ROWS-1:0][OUT_DIM-1:0][WIDTH-1:0] warr_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   lfsr_q [OUT_DIM];
  logic [15:0]   lfsr_d [OUT_DIM];
  warr_t         weights_q, weights_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic [15:0]   count_q, count_d;

  function automatic logic [15:0] lane_seed(input int j);
    logic [31:0] p;
    logic [15:0] s;
    p = 32'(j) * 32'h0000_9E37;
    s = SEED ^ p[15:0];
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [WIDTH-1:0] init_value(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] lane);
    logic signed [WIDTH-1:0] r;
    r = lane;
    case (m)
      2'b01:   init_value = r;
      2'b10:   init_value = r >>> INIT_SHIFT;
      default: init_value = '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] store_value(input logic [WIDTH-1:0] v);
    int sv;
    sv = $signed(v);
    if (CLAMP_ON && (sv > CLAMP_LIMIT))  return WIDTH'(CLAMP_LIMIT);
    if (CLAMP_ON && (sv < -CLAMP_LIMIT)) return WIDTH'(-CLAMP_LIMIT);
    return v;
  endfunction

  // A pending init request blocks the update so init always wins a tie.
  assign bus.update_ready  = (state_q == S_RUN) && !bus.init_req;
  assign bus.weights       = weights_q;
  assign bus.weights_valid = valid_q;
  assign bus.init_busy     = busy_q;
  assign bus.update_count  = count_q;
  assign dbg_state         = state_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    mode_d    = mode_q;
    lfsr_d    = lfsr_q;
    weights_d = weights_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE: begin
        mode_d  = bus.mode;
        row_d   = '0;
        busy_d  = 1'b1;
        state_d = S_INIT;
      end
      S_INIT: begin
        for (int r = 0; r < ROWS; r++) begin
          if (row_q == RW'(r)) begin
            for (int c = 0; c < OUT_DIM; c++) begin
              weights_d[r][c] = init_value(mode_q, lfsr_q[c][WIDTH-1:0]);
            end
          end
        end
        for (int c = 0; c < OUT_DIM; c++) begin
          lfsr_d[c] = {lfsr_q[c][14:0],
                       lfsr_q[c][15] ^ lfsr_q[c][13] ^ lfsr_q[c][12] ^ lfsr_q[c][10]};
        end
        if (row_q == RW'(IN_DIM)) begin
          state_d = S_RUN;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_RUN: begin
        if (bus.init_req) begin
          state_d = S_INIT;
          mode_d  = bus.mode;
          row_d   = '0;
          count_d = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
        end else if (bus.update_valid) begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < OUT_DIM; c++) begin
              weights_d[r][c] = store_value(bus.update_weights[r][c]);
            end
          end
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      mode_q    <= 2'b00;
      weights_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      for (int j = 0; j < OUT_DIM; j++) lfsr_q[j] <= lane_seed(j);
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      mode_q    <= mode_d;
      weights_q <= weights_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      for (int j = 0; j < OUT_DIM; j++) lfsr_q[j] <= lfsr_d[j];
    end
  end
endmodule
